// File: rtl/back_end_arbiter_if.sv
// Bundle of the actor-side token handshake and the single FSL master link used by back_end_arbiter.
// FSL_M_CONTROL exists only when BACK_END_ARB_LAST_EN is defined.
interface back_end_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int DATAW  = 32
);
    logic [NPORTS-1:0]       OUT_send;
    logic [NPORTS*DATAW-1:0] OUT_data;
    logic [NPORTS-1:0]       IN_ack;
    logic [NPORTS-1:0]       IN_rdy;
    logic                    FSL_M_WRITE;
    logic [DATAW-1:0]        FSL_M_DATA;
    logic                    FSL_M_FULL;
`ifdef BACK_END_ARB_LAST_EN
    logic                    FSL_M_CONTROL;

    modport master (
        input  OUT_send, OUT_data, FSL_M_FULL,
        output IN_ack, IN_rdy, FSL_M_WRITE, FSL_M_DATA, FSL_M_CONTROL
    );
    modport slave (
        output OUT_send, OUT_data, FSL_M_FULL,
        input  IN_ack, IN_rdy, FSL_M_WRITE, FSL_M_DATA, FSL_M_CONTROL
    );
`else
    modport master (
        input  OUT_send, OUT_data, FSL_M_FULL,
        output IN_ack, IN_rdy, FSL_M_WRITE, FSL_M_DATA
    );
    modport slave (
        output OUT_send, OUT_data, FSL_M_FULL,
        input  IN_ack, IN_rdy, FSL_M_WRITE, FSL_M_DATA
    );
`endif
endinterface

// File: rtl/back_end_arbiter.sv
// Round-robin burst arbiter sharing one FSL master link among NPORTS actor outputs.
// Optional feature macro BACK_END_ARB_LAST_EN adds FSL_M_CONTROL marking the last token of each burst.
//
// Handshake: a token moves from the owner port to FSL in any BURST cycle where
// OUT_send[g]=1, FSL_M_FULL=0 and the burst is not yet complete; that same cycle
// FSL_M_WRITE=1 and IN_ack[g]=1. Nothing is buffered; data is passed combinationally.
module back_end_arbiter #(
    parameter int NPORTS    = 4,
    parameter int SIZECOUNT = 12,
    parameter int DATAW     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SIZECOUNT-1:0] size,
    back_end_arbiter_if.master   fsl,
    output logic [NPORTS-1:0]    grant,
    output logic                 busy,
    output logic [1:0]           state_dbg   // 0 IDLE, 1 ARB, 2 BURST
);
    localparam int PW = $clog2(NPORTS);
    localparam logic [SIZECOUNT-1:0] ONE = SIZECOUNT'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, BURST = 2'd2} state_t;

    state_t               state, state_n;
    logic [NPORTS-1:0]    grant_n;
    logic [PW-1:0]        last, last_n;
    logic [SIZECOUNT-1:0] count, count_n, size_q, size_q_n;

    logic                 hit;
    logic [PW-1:0]        hit_idx;
    logic [PW-1:0]        cand;
    int                   scan_idx;
    logic                 in_burst, owner_send, wr, last_tok;
    logic [DATAW-1:0]     data_sel;

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = last;
        cand     = last;
        scan_idx = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            scan_idx = (int'(last) + k) % NPORTS;
            cand     = PW'(scan_idx);
            if (!hit && fsl.OUT_send[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i]) data_sel = data_sel | fsl.OUT_data[i*DATAW +: DATAW];
        end
    end

    // count never passes size_q-1 while writing, so it cannot wrap even at the maximum size.
    assign in_burst   = (state == BURST);
    assign owner_send = |(fsl.OUT_send & grant);
    assign wr         = in_burst && owner_send && !fsl.FSL_M_FULL && (count < size_q);
    assign last_tok   = (count == size_q - ONE);

    assign fsl.FSL_M_WRITE = wr;
    assign fsl.FSL_M_DATA  = in_burst ? data_sel : '0;
    assign fsl.IN_ack      = wr ? grant : '0;
    assign fsl.IN_rdy      = (in_burst && !fsl.FSL_M_FULL) ? grant : '0;
`ifdef BACK_END_ARB_LAST_EN
    assign fsl.FSL_M_CONTROL = wr && last_tok;
`endif

    assign busy      = in_burst;
    assign state_dbg = state;

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_n   = last;
        size_q_n = size_q;
        count_n  = count;
        case (state)
            IDLE: begin
                if (en) state_n = ARB;
            end
            ARB: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (hit) begin
                    // A zero-size hit still moves the pointer so the port loses its turn.
                    last_n = hit_idx;
                    if (size != '0) begin
                        grant_n  = NPORTS'(1) << hit_idx;
                        size_q_n = size;
                        count_n  = '0;
                        state_n  = BURST;
                    end
                end
            end
            BURST: begin
                if (wr) begin
                    count_n = count + ONE;
                    if (last_tok) begin
                        grant_n = '0;
                        state_n = en ? ARB : IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            last   <= PW'(NPORTS - 1);
            size_q <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            last   <= last_n;
            size_q <= size_q_n;
            count  <= count_n;
        end
    end
endmodule

// File: tb/tb_back_end_arbiter.sv
// Self-checking bench for back_end_arbiter: token sources, a round-robin burst reference model
// feeding an expected queue, and a monitor that compares every FSL write against it.
module tb_back_end_arbiter;
  localparam int NPORTS    = 4;
  localparam int SIZECOUNT = 12;
  localparam int DATAW     = 32;
  localparam int PW        = 2;
  localparam int W         = DATAW + PW + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en;
  logic [SIZECOUNT-1:0] size;
  logic [NPORTS-1:0]    grant;
  logic                 busy;
  logic [1:0]           state_dbg;

  back_end_arbiter_if #(.NPORTS(NPORTS), .DATAW(DATAW)) bus ();

  back_end_arbiter #(.NPORTS(NPORTS), .SIZECOUNT(SIZECOUNT), .DATAW(DATAW)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .size(size),
    .fsl(bus.master),
    .grant(grant),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // bench state
  logic [DATAW-1:0] src_q[NPORTS][$];
  logic [DATAW-1:0] mdl_q[NPORTS][$];
  logic [W-1:0]     exp_q[$];
  int               mdl_last;
  int               n_checks = 0;
  int               n_pass = 0;
  int               wr_count = 0;
  int               full_pct = 0;
  int               drop_pct = 0;
  logic [NPORTS-1:0] acked_n = '0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // reference model: whole bursts of sz tokens, owners chosen round-robin among ports holding tokens
  function automatic void model_bursts(input int nb, input int sz);
    int b = 0;
    while (nb < 0 || b < nb) begin
      int p = -1;
      for (int k = 1; k <= NPORTS; k++) begin
        int c = (mdl_last + k) % NPORTS;
        if (p < 0 && mdl_q[c].size() > 0) p = c;
      end
      if (p < 0) break;
      mdl_last = p;
      for (int t = 0; t < sz; t++) begin
        logic [DATAW-1:0] d = mdl_q[p].pop_front();
        logic [PW-1:0] pp = PW'(p);
        logic lf = (t == sz - 1);
        exp_q.push_back({lf, pp, d});
      end
      b++;
    end
  endfunction

  // a zero-size request only moves the round-robin pointer to the first requester
  function automatic void model_skip();
    int p = -1;
    for (int k = 1; k <= NPORTS; k++) begin
      int c = (mdl_last + k) % NPORTS;
      if (p < 0 && mdl_q[c].size() > 0) p = c;
    end
    if (p >= 0) mdl_last = p;
  endfunction

  // driver tasks
  task automatic load(input int port, input int n);
    for (int i = 0; i < n; i++) begin
      logic [DATAW-1:0] d = $urandom;
      src_q[port].push_back(d);
      mdl_q[port].push_back(d);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NPORTS; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    acked_n = '0;
    mdl_last = NPORTS - 1;
  endtask

  task automatic wait_exp_empty(input int budget, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick(1);
      c++;
    end
    check(exp_q.size() == 0, name, exp_q.size(), 0);
    tick(3);
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int c = 0;
    while (wr_count < target && c < budget) begin
      tick(1);
      c++;
    end
    check(wr_count >= target, name, wr_count, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(grant == '0, {tag, "_grant"}, grant, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(state_dbg == 2'd0, {tag, "_state"}, state_dbg, 0);
    check(bus.FSL_M_WRITE == 1'b0, {tag, "_write"}, bus.FSL_M_WRITE, 0);
    check(bus.FSL_M_DATA == '0, {tag, "_data"}, bus.FSL_M_DATA, 0);
    check(bus.IN_ack == '0, {tag, "_ack"}, bus.IN_ack, 0);
    check(bus.IN_rdy == '0, {tag, "_rdy"}, bus.IN_rdy, 0);
  endtask

  // source driver: pops acked tokens, presents queue heads, random FULL and owner send drops
  initial begin
    bus.OUT_send   = '0;
    bus.OUT_data   = '0;
    bus.FSL_M_FULL = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NPORTS; i++)
        if (acked_n[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      acked_n = '0;
      bus.FSL_M_FULL = ($urandom_range(0, 99) < full_pct);
      for (int i = 0; i < NPORTS; i++) begin
        bus.OUT_send[i] = (src_q[i].size() > 0) && !(grant[i] && ($urandom_range(0, 99) < drop_pct));
        bus.OUT_data[i*DATAW +: DATAW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        int gi = -1;
        logic [W-1:0] e;
        for (int i = 0; i < NPORTS; i++) if (grant[i]) gi = i;
        check($onehot0(grant), "grant_onehot", grant, 0);
        check(busy == (grant != '0), "busy_vs_grant", busy, grant != '0);
        check(bus.IN_rdy == ((busy && !bus.FSL_M_FULL) ? grant : '0), "in_rdy", bus.IN_rdy,
              (busy && !bus.FSL_M_FULL) ? grant : '0);
        check(bus.IN_ack == (bus.FSL_M_WRITE ? grant : '0), "in_ack", bus.IN_ack,
              bus.FSL_M_WRITE ? grant : '0);
        if (bus.FSL_M_FULL) check(!bus.FSL_M_WRITE, "write_while_full", bus.FSL_M_WRITE, 0);
        if (!busy) check(!bus.FSL_M_WRITE && bus.FSL_M_DATA == '0, "idle_outputs",
                         {bus.FSL_M_WRITE, bus.FSL_M_DATA}, 0);
        acked_n = bus.IN_ack;
        if (bus.FSL_M_WRITE) begin
          wr_count++;
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_write", bus.FSL_M_DATA, 0);
          end else begin
            e = exp_q.pop_front();
            check(bus.FSL_M_DATA == e[DATAW-1:0], "fsl_data", bus.FSL_M_DATA, e[DATAW-1:0]);
            check(gi == int'(e[DATAW +: PW]), "fsl_port", gi, e[DATAW +: PW]);
`ifdef BACK_END_ARB_LAST_EN
            check(bus.FSL_M_CONTROL == e[W-1], "fsl_control", bus.FSL_M_CONTROL, e[W-1]);
`endif
          end
        end
      end
    end
  end

  // stimulus sequence
  initial begin
    int base;
    en = 1'b0;
    size = 12'd3;
    clear_all();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // single requester, size 3: grant one cycle after send, then regranted
    en = 1'b1;
    tick(3);
    check(state_dbg == 2'd1, "arb_state", state_dbg, 1);
    load(0, 6);
    model_bursts(-1, 3);
    tick(1);
    check(grant == '0, "grant_before", grant, 0);
    tick(1);
    check(grant == 4'b0001, "grant_latency", grant, 4'b0001);
    wait_exp_empty(200, "drain_single");

    // all ports requesting, size 2
    size = 12'd2;
    for (int p = 0; p < NPORTS; p++) load(p, 4);
    model_bursts(-1, 2);
    wait_exp_empty(500, "drain_rr");

    // stalls from FSL_M_FULL on a size-4 burst
    size = 12'd4;
    full_pct = 50;
    load(1, 4);
    model_bursts(-1, 4);
    wait_exp_empty(500, "drain_full");
    full_pct = 0;

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      int sz = $urandom_range(1, 4);
      size = SIZECOUNT'(sz);
      full_pct = $urandom_range(0, 40);
      drop_pct = $urandom_range(0, 30);
      for (int p = 0; p < NPORTS; p++) load(p, sz * $urandom_range(0, 3));
      model_bursts(-1, sz);
      wait_exp_empty(3000, "drain_random");
    end
    full_pct = 0;
    drop_pct = 0;

    // size 0: pointer advances to port 2, no grant; port 3 then wins
    size = 12'd0;
    load(2, 3);
    model_skip();
    tick(6);
    check(busy == 1'b0, "size0_busy", busy, 0);
    check(grant == '0, "size0_grant", grant, 0);
    en = 1'b0;
    tick(2);
    check(state_dbg == 2'd0, "size0_idle", state_dbg, 0);
    load(3, 3);
    size = 12'd3;
    model_bursts(-1, 3);
    en = 1'b1;
    wait_exp_empty(300, "drain_size0");

    // en dropped during the 2nd token of a 3-token burst
    load(0, 3);
    load(1, 3);
    model_bursts(1, 3);
    base = wr_count;
    wait_writes(base + 2, 100, "en_drop_reach");
    en = 1'b0;
    wait_exp_empty(100, "en_drop_burst_done");
    check(state_dbg == 2'd0, "en_drop_idle", state_dbg, 0);
    tick(5);
    check(busy == 1'b0, "en_drop_stays_idle", busy, 0);
    model_bursts(-1, 3);
    en = 1'b1;
    wait_exp_empty(200, "en_resume");

    // maximum burst size
    size = {SIZECOUNT{1'b1}};
    full_pct = 10;
    load(1, (1 << SIZECOUNT) - 1);
    model_bursts(-1, (1 << SIZECOUNT) - 1);
    wait_exp_empty(12000, "drain_max");
    full_pct = 0;

    // asynchronous reset with count = 1
    size = 12'd3;
    load(0, 3);
    model_bursts(-1, 3);
    base = wr_count;
    wait_writes(base + 1, 100, "rst_reach");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    clear_all();
    tick(2);
    rst = 1'b0;
    load(1, 3);
    load(0, 3);
    model_bursts(-1, 3);
    wait_exp_empty(300, "drain_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
